// File: rtl/pulse_seq_gen.sv
// Pulse sequence generator for CW, Hahn-echo and CPMG: pump/pi gate, blocking gate,
// scope sync and phase select, with a double-buffered configuration applied at period wrap.
module pulse_seq_gen #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned T_W   = 16,
    parameter int unsigned NP_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] per,
    input  logic [T_W-1:0]   p1wid,
    input  logic [T_W-1:0]   p2wid,
    input  logic [T_W-1:0]   del,
    input  logic [NP_W-1:0]  npi,
    input  logic             bl,
    input  logic [7:0]       p_bl,
    input  logic [T_W-1:0]   p_bl_off,
    input  logic             phase_cyc,
    output logic             sync_on,
    output logic             pulse_on,
    output logic             inhib,
    output logic [1:0]       phase,
    output logic [NP_W-1:0]  echo_idx,
    output logic             cfg_pending
);

    localparam int unsigned SW = CNT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_CW, S_PULSED} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] per;
        logic [T_W-1:0]   p1wid;
        logic [T_W-1:0]   p2wid;
        logic [T_W-1:0]   del;
        logic [NP_W-1:0]  npi;
        logic             bl;
        logic [7:0]       p_bl;
        logic [T_W-1:0]   p_bl_off;
        logic             phase_cyc;
    } cfg_t;

    state_t           state_q, state_d, run_mode;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cyc_q, cyc_d;
    logic             cfg_pending_q, cfg_pending_d;
    cfg_t             act_q, act_d, sh_q, sh_d, cfg_in;
    logic             running, wrap, restart, apply;

    // Schedule trackers: count of events begun, next event time, last event start.
    logic [NP_W-1:0]  pi_n_q, pi_n_d, win_n_q, win_n_d, cls_n_q, cls_n_d;
    logic [SW-1:0]    pi_ns_q, pi_ns_d, win_ns_q, win_ns_d, cls_ns_q, cls_ns_d;
    logic [SW-1:0]    pi_ls_q, pi_ls_d, win_ls_q, win_ls_d;

    logic [SW-1:0]    t_c, spacing_c, s1_c, w1_c, c1_c, pi_ls_c, win_ls_c;
    logic [T_W-1:0]   gap_c;
    logic [NP_W-1:0]  pi_na_c, win_na_c, echo_c;
    logic             pulsed_c, pump_c, pi_hit_c, win_hit_c, cls_hit_c;
    logic             pi_on_c, win_on_c, sync_c;

    logic             sync_on_q, sync_on_d, pulse_on_q, pulse_on_d, inhib_q, inhib_d;
    logic [1:0]       phase_q, phase_d;
    logic [NP_W-1:0]  echo_idx_q, echo_idx_d;

    // Mode, counter and shadow/active configuration handover.
    always_comb begin : ctrl_comb
        cfg_in           = '0;
        cfg_in.per       = per;
        cfg_in.p1wid     = p1wid;
        cfg_in.p2wid     = p2wid;
        cfg_in.del       = del;
        cfg_in.npi       = npi;
        cfg_in.bl        = bl;
        cfg_in.p_bl      = p_bl;
        cfg_in.p_bl_off  = p_bl_off;
        cfg_in.phase_cyc = phase_cyc;

        running       = (state_q != S_IDLE);
        wrap          = running && (cnt_q == act_q.per);
        restart       = !running || wrap;
        apply         = cfg_pending_q && restart;
        act_d         = apply ? sh_q : act_q;
        sh_d          = cfg_load ? cfg_in : sh_q;
        cfg_pending_d = cfg_load || (cfg_pending_q && !apply);
        run_mode      = (act_d.npi == '0) ? S_CW : S_PULSED;

        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        cyc_d   = cyc_q;
        if (!running) begin
            cnt_d = '0;
            if (enable) state_d = run_mode;
        end else if (wrap) begin
            cnt_d   = '0;
            cyc_d   = ~cyc_q;
            state_d = enable ? run_mode : S_IDLE;
        end
    end

    // Event tracking at the current count; pulses and windows repeat every 2*del+p2wid.
    always_comb begin : sched_comb
        t_c       = SW'(cnt_q);
        pulsed_c  = (state_q == S_PULSED);
        pump_c    = t_c < SW'(act_q.p1wid);
        spacing_c = SW'(act_q.del) + SW'(act_q.del) + SW'(act_q.p2wid);

        pi_hit_c  = pulsed_c && (pi_n_q < act_q.npi) && (t_c == pi_ns_q);
        pi_na_c   = pi_n_q + NP_W'(pi_hit_c);
        pi_ls_c   = pi_hit_c ? t_c : pi_ls_q;
        pi_on_c   = (pi_na_c != '0) && (t_c < pi_ls_c + SW'(act_q.p2wid));

        win_hit_c = pulsed_c && (win_n_q < act_q.npi) && (t_c == win_ns_q);
        win_na_c  = win_n_q + NP_W'(win_hit_c);
        win_ls_c  = win_hit_c ? t_c : win_ls_q;
        win_on_c  = (win_na_c != '0) && (t_c < win_ls_c + SW'(act_q.p_bl_off));

        cls_hit_c = pulsed_c && (act_q.p_bl_off != '0) && (cls_n_q < act_q.npi)
                    && (t_c == cls_ns_q);
        echo_c    = cls_n_q + NP_W'(cls_hit_c);
        sync_c    = (pi_na_c < act_q.npi) || pi_on_c;

        // First event times for the set that will be active in the coming period.
        gap_c = (act_d.del > T_W'(act_d.p_bl)) ? act_d.del - T_W'(act_d.p_bl) : '0;
        s1_c  = SW'(act_d.p1wid) + SW'(act_d.del);
        w1_c  = s1_c + SW'(act_d.p2wid) + SW'(gap_c);
        c1_c  = w1_c + SW'(act_d.p_bl_off);

        pi_n_d   = pi_na_c;
        pi_ns_d  = pi_hit_c ? pi_ns_q + spacing_c : pi_ns_q;
        pi_ls_d  = pi_ls_c;
        win_n_d  = win_na_c;
        win_ns_d = win_hit_c ? win_ns_q + spacing_c : win_ns_q;
        win_ls_d = win_ls_c;
        cls_n_d  = echo_c;
        cls_ns_d = cls_hit_c ? cls_ns_q + spacing_c : cls_ns_q;
        if (restart) begin
            pi_n_d   = '0;
            pi_ns_d  = s1_c;
            pi_ls_d  = '0;
            win_n_d  = '0;
            win_ns_d = w1_c;
            win_ls_d = '0;
            cls_n_d  = '0;
            cls_ns_d = c1_c;
        end
    end

    // Output decode; registered so outputs trail the count by one cycle.
    always_comb begin : out_comb
        pulse_on_d = 1'b0;
        sync_on_d  = 1'b0;
        inhib_d    = 1'b0;
        echo_idx_d = '0;
        phase_d    = phase_q;
        case (state_q)
            S_CW: begin
                pulse_on_d = 1'b1;
                sync_on_d  = pump_c;
                phase_d    = 2'd0;
            end
            S_PULSED: begin
                pulse_on_d = pump_c || pi_on_c;
                sync_on_d  = sync_c;
                inhib_d    = act_q.bl && !win_on_c;
                echo_idx_d = echo_c;
                if (!act_q.phase_cyc) begin
                    phase_d = 2'd0;
                end else if (pump_c) begin
                    phase_d = {cyc_q, 1'b0};
                end else if (pi_on_c) begin
                    phase_d = (act_q.npi > NP_W'(1)) ? 2'd1 : {cyc_q, 1'b0};
                end
            end
            default: phase_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cyc_q         <= 1'b0;
            cfg_pending_q <= 1'b0;
            act_q         <= '0;
            sh_q          <= '0;
            pi_n_q        <= '0;
            pi_ns_q       <= '0;
            pi_ls_q       <= '0;
            win_n_q       <= '0;
            win_ns_q      <= '0;
            win_ls_q      <= '0;
            cls_n_q       <= '0;
            cls_ns_q      <= '0;
            sync_on_q     <= 1'b0;
            pulse_on_q    <= 1'b0;
            inhib_q       <= 1'b0;
            phase_q       <= 2'd0;
            echo_idx_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cyc_q         <= cyc_d;
            cfg_pending_q <= cfg_pending_d;
            act_q         <= act_d;
            sh_q          <= sh_d;
            pi_n_q        <= pi_n_d;
            pi_ns_q       <= pi_ns_d;
            pi_ls_q       <= pi_ls_d;
            win_n_q       <= win_n_d;
            win_ns_q      <= win_ns_d;
            win_ls_q      <= win_ls_d;
            cls_n_q       <= cls_n_d;
            cls_ns_q      <= cls_ns_d;
            sync_on_q     <= sync_on_d;
            pulse_on_q    <= pulse_on_d;
            inhib_q       <= inhib_d;
            phase_q       <= phase_d;
            echo_idx_q    <= echo_idx_d;
        end
    end

    assign sync_on     = sync_on_q;
    assign pulse_on    = pulse_on_q;
    assign inhib       = inhib_q;
    assign phase       = phase_q;
    assign echo_idx    = echo_idx_q;
    assign cfg_pending = cfg_pending_q;

endmodule

// File: doc/pulse_seq_gen.md
# pulse_seq_gen

Parametrised successor to the single-channel pulse generator. Produces the pump/pi-pulse switch gate, blocking-switch gate, scope sync and a 2-bit phase select for CW, Hahn-echo and CPMG sequences. All timing registers are width-parametrised, and new configurations are double-buffered so that changes take effect only at a period boundary. Sits between the UART configuration decoder and the RF switch / phase-shifter pins, on the PLL clock domain.

## Interface
- CNT_W, 32: width of the period counter and of all absolute schedule times.
- T_W, 16: width of the pulse-width, delay and window-width fields.
- NP_W, 8: width of the pi-pulse count and of `echo_idx`.
- clk  in  1  the single clock (200 MHz PLL clock); all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request.
- cfg_load  in  1  single-cycle strobe; captures all configuration inputs into the shadow set.
- per  in  CNT_W  period length minus 1, in cycles.
- p1wid, p2wid  in  T_W  pump and pi pulse widths (cycles).
- del  in  T_W  pump-to-first-pi delay; half of the pi-to-pi spacing.
- npi  in  NP_W  0 = CW, 1 = Hahn, >1 = CPMG with `npi` pi pulses.
- bl  in  1  blocking enable.
- p_bl  in  8  window lead, i.e. cycles before the echo centre.
- p_bl_off  in  T_W  window width.
- phase_cyc  in  1  phase-cycling enable.
- sync_on, pulse_on, inhib  out  1  scope trigger, switch gate, blocking gate.
- phase  out  2  phase select: 0=x, 1=y, 2=−x.
- echo_idx  out  NP_W  windows completed in the current period.
- cfg_pending  out  1  shadow set loaded but not yet active.

## Operation
- FSM states: IDLE, CW, PULSED.
  - From IDLE, `enable`=1 moves to CW if active `npi`==0, otherwise to PULSED. The counter starts at 0.
  - In CW or PULSED, a wrap (counter==`per`, so the next count is 0) copies the shadow set into the active set if `cfg_pending`, then re-selects CW or PULSED from the new `npi`. It enters IDLE instead if `enable`==0.
  - In IDLE, `cfg_load` writes the shadow set and copies it to the active set on the next cycle.
- Counter: 0..`per`, then wraps. Period = `per`+1 cycles. `per`=0 gives a 1-cycle period.
- PULSED schedule, at counter value t, with all sums computed in CNT_W+1 bits:
  - Pump: t in [0, p1wid).
  - Pi k (k=1..npi): S_k = p1wid + del + (k−1)(2·del + p2wid); E_k = S_k + p2wid. Pulse active for t in [S_k, E_k).
  - Window k: start W_k = max(E_k + del − p_bl, E_k). `inhib`=0 for t in [W_k, W_k + p_bl_off); otherwise `inhib`=`bl`.
  - `sync_on`=1 for t in [0, E_npi).
  - Any event whose time exceeds `per` is not emitted. An open interval is truncated at the wrap.
  - Overlapping windows merge, so `inhib` stays 0 across them.
- CW: `pulse_on`=1, `inhib`=0, `sync_on`=1 for t < p1wid, `phase`=0.
- Phase:
  - `phase_cyc`=0: `phase`=0.
  - `phase_cyc`=1: during the pump, `phase` = 2·cyc_bit. During the pi pulses, `phase`=1 if `npi`>1, else 2·cyc_bit.
  - `phase` is held between pulses. cyc_bit toggles on every wrap and resets to 0.
- `echo_idx` increments when each window closes and clears at the wrap.
- `cfg_load` while `cfg_pending` overwrites the shadow set; the last load wins. `cfg_pending` clears in the cycle the set becomes active.
- `cfg_load` coinciding with a wrap: the previous shadow set is applied, and the new load stays pending.

## Timing
- Reset: counter=0, state=IDLE, cyc_bit=0, `cfg_pending`=0, active and shadow sets zero. All outputs are 0.
- Reset mid-period takes effect on the next edge, with no completion of the current period.
- Output latency is 1 cycle: outputs in cycle n+1 reflect the counter value in cycle n. The first cycle after leaving IDLE therefore shows all-zero outputs.
- In IDLE all outputs are 0, including `inhib` regardless of `bl`.
- Deasserting `enable` finishes the current period. Outputs are 0 from the cycle after the wrap.
- Widths of 0 produce no pulse or window. `npi` > the count that fits in `per` emits only the pulses that fit.
- The active set never changes mid-period.

## Test plan
- Hahn. Load per=999, p1wid=30, del=200, p2wid=30, npi=1, p_bl=50, p_bl_off=100, bl=1, enable=1. Required response, in counter values +1 cycle:
  - `pulse_on` high for t 0–29 and 230–259.
  - `sync_on` high for t 0–259.
  - `inhib` low for t 410–509.
  - `echo_idx` reaches 1.
- CPMG. Same settings with npi=3, per=1999. Required response:
  - Pi pulses at t 230–259, 660–689, 1090–1119.
  - Windows at t 410–509, 840–939, 1270–1369.
  - `sync_on` falls at t=1120.
  - `phase_cyc`=1: `phase`=1 on the pi pulses; pump `phase` alternates 0/2 across successive periods.
- Double buffer. `cfg_load` with p1wid=60 at t=500 of a running period. Required response: the current period still shows a 30-cycle pump; the next period shows 60; `cfg_pending` is high from t=501 until the wrap.
- Boundary. Set p_bl=250 > del+p2wid. Required response: the window starts at E_k (t=260). Separately, set per=240 with npi=1: the pi pulse is truncated at the wrap and no window is emitted.
- CW and enable. With npi=0: `pulse_on`=1 continuously and `inhib`=0. Then drop `enable`: outputs go to 0 after the wrap. Then assert reset mid-period: all outputs are 0 on the next edge and the counter returns to 0.
